wb_ram128_bridge: RTL and testbench
===================================

// Module: wb_ram128_bridge
// PURPOSE
//  Wishbone classic slave that fronts one RAM128 SRAM macro (1-cycle read latency, byte write enables).
//  Sits between the management-SoC Wishbone interconnect and the macro port.
//  Decodes its window, drives EN0/WE0/A0/Di0 from registers, captures Do0 and holds it on the bus,
//  because the macro forces Do0 to 0 while EN0 is low.
// PARAMETERS
//  COLS       1             macro column count; must match the attached RAM128
//  BASE_ADDR  32'h0100_0000 byte base of window; window = 4*2**A_WIDTH bytes, base aligned to it
//  A_WIDTH    (localparam)  7+$clog2(COLS); macro word-address width
// PORTS
//  wb_clk_i   in   1        single clock; also clocks the macro
//  wb_rst_i   in   1        reset, synchronous, active-high
//  wbs_cyc_i  in   1        bus cycle
//  wbs_stb_i  in   1        strobe
//  wbs_we_i   in   1        1=write
//  wbs_sel_i  in   4        byte selects
//  wbs_adr_i  in   32       byte address
//  wbs_dat_i  in   32       write data
//  wbs_ack_o  out  1        one-cycle acknowledge
//  wbs_dat_o  out  32       read data, held until next read completes
//  ram_en0    out  1        to macro EN0
//  ram_we0    out  4        to macro WE0
//  ram_a0     out  A_WIDTH  to macro A0 (word address = wbs_adr_i[A_WIDTH+1:2])
//  ram_di0    out  32       to macro Di0
//  ram_do0    in   32       from macro Do0
// BEHAVIOUR
//  - Hit = cyc&stb & (wbs_adr_i[31:A_WIDTH+2]==BASE_ADDR[31:A_WIDTH+2]). Misses ignored: no ack, no RAM access.
//  - FSM: IDLE -> ISSUE -> (write) ACK | (read) CAPT [-> HOLD] -> ACK -> IDLE.
//  - IDLE, hit at edge E0: register ram_en0=1, ram_we0=we?sel:0, ram_a0, ram_di0=dat_i; go ISSUE.
//  - ISSUE, edge E1: macro samples request; ram_en0/ram_we0 cleared to 0.
//    Write: wbs_ack_o=1 for cycle E1..E2.
//    Read: go CAPT.
//  - CAPT, edge E2: wbs_dat_o<=ram_do0; wbs_ack_o=1 for E2..E3.
//  - ACK lasts exactly one cycle, then IDLE. stb is ignored in ACK.
//    Earliest next request is sampled one edge after ack drops; no back-to-back pipelining.
//  - Write with sel=0: macro enabled with WE0=0; still acked. Write never changes wbs_dat_o.
//  - Master drops cyc after E0: RAM access still completes (write commits); ack suppressed; FSM returns to IDLE.
//  - Reset: all outputs 0, state IDLE on the next edge. A request the macro sampled before the reset edge may
//    have committed; otherwise no RAM access; no ack.
//  - ram_en0 is high exactly one cycle per accepted access and low otherwise (macro power).
// CONFIGURATION
//  Macro RAM128_BRIDGE_RDREG_EN:
//   defined: extra HOLD state; ram_do0 is registered at E2, copied to wbs_dat_o, and acked at E3.
//            Read ack is high for E3..E4. Write timing is unchanged.
//   undefined: read timing as in BEHAVIOUR (ack high for E2..E3); no HOLD state.
// TESTING
//  1. Reset: assert wb_rst_i 2 cycles mid-read -> ack/en/we/dat_o all 0; next read works normally.
//  2. Write 0xDEADBEEF sel=4'hF @BASE+0x10, then read @BASE+0x10
//     -> ram_a0=4, write ack at E1, read returns 0xDEADBEEF, ack at E2 (E3 with RDREG_EN).
//  3. Write 0x000000AA sel=4'h1 over 0x11223344 at @BASE+0x0 -> readback 0x112233AA.
//  4. Access to BASE+4*2**A_WIDTH (just outside window) -> no ack for 16 cycles; ram_en0 stays 0.
//  5. Read then idle 5 cycles -> wbs_dat_o holds value while ram_do0 is 0; ram_en0 high exactly 1 cycle per access.
//  6. Write @last word (A0=2**A_WIDTH-1) then read @word 0 -> no aliasing; cyc dropped after E0 -> no ack, write committed.

Source files
------------

// File: rtl/wb_ram128_bridge.sv
// Wishbone classic slave in front of a RAM128 macro: registered macro request, captured and held read data.
// Optional macro RAM128_BRIDGE_RDREG_EN adds a register stage on ram_do0 (read ack one cycle later).
module wb_ram128_bridge #(
  parameter int          COLS      = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  localparam int         A_WIDTH   = 7 + $clog2(COLS)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               ram_en0,
  output logic [3:0]         ram_we0,
  output logic [A_WIDTH-1:0] ram_a0,
  output logic [31:0]        ram_di0,
  input  logic [31:0]        ram_do0
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd4;
`ifdef RAM128_BRIDGE_RDREG_EN
  localparam logic [2:0] S_HOLD  = 3'd3;
  logic [31:0] rd_q;
`endif

  logic [2:0] state;
  logic       is_write;
  logic       aborted;
  logic       hit;
  logic       unused_adr;

  always_comb begin
    hit = wbs_cyc_i & wbs_stb_i &
          (wbs_adr_i[31:A_WIDTH+2] == BASE_ADDR[31:A_WIDTH+2]);
    unused_adr = ^wbs_adr_i[1:0];
  end

  // Once the master abandons the cycle, the macro access still runs to completion
  // but the ack is withheld; 'aborted' remembers a drop seen on an earlier edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      ram_en0   <= 1'b0;
      ram_we0   <= '0;
      ram_a0    <= '0;
      ram_di0   <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      is_write  <= 1'b0;
      aborted   <= 1'b0;
`ifdef RAM128_BRIDGE_RDREG_EN
      rd_q      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            ram_en0  <= 1'b1;
            ram_we0  <= wbs_we_i ? wbs_sel_i : '0;
            ram_a0   <= wbs_adr_i[A_WIDTH+1:2];
            ram_di0  <= wbs_dat_i;
            is_write <= wbs_we_i;
            aborted  <= 1'b0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ram_en0 <= 1'b0;
          ram_we0 <= '0;
          if (is_write) begin
            wbs_ack_o <= wbs_cyc_i & ~aborted;
            state     <= S_ACK;
          end else begin
            aborted <= aborted | ~wbs_cyc_i;
            state   <= S_CAPT;
          end
        end
`ifdef RAM128_BRIDGE_RDREG_EN
        S_CAPT: begin
          rd_q    <= ram_do0;
          aborted <= aborted | ~wbs_cyc_i;
          state   <= S_HOLD;
        end
        S_HOLD: begin
          wbs_dat_o <= rd_q;
          wbs_ack_o <= wbs_cyc_i & ~aborted;
          state     <= S_ACK;
        end
`else
        S_CAPT: begin
          wbs_dat_o <= ram_do0;
          wbs_ack_o <= wbs_cyc_i & ~aborted;
          state     <= S_ACK;
        end
`endif
        S_ACK: begin
          wbs_ack_o <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram128_bridge.sv
// Bench for wb_ram128_bridge: RAM128 macro stand-in, transaction-level expectation model, per-cycle compare.
module tb_wb_ram128_bridge;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int          WIN  = 512;
  localparam int          NCYC = 2048;
`ifdef RAM128_BRIDGE_RDREG_EN
  localparam int RDLAT = 3;
`else
  localparam int RDLAT = 2;
`endif

  logic        wb_clk_i, wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ram_en0;
  logic [3:0]  ram_we0;
  logic [6:0]  ram_a0;
  logic [31:0] ram_di0;
  logic [31:0] ram_do0;

  wb_ram128_bridge #(.COLS(1), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ram_en0(ram_en0), .ram_we0(ram_we0), .ram_a0(ram_a0),
    .ram_di0(ram_di0), .ram_do0(ram_do0)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // RAM128 stand-in: 1-cycle read latency, byte write enables, Do0 forced to 0 when disabled.
  logic [31:0] macro_mem [128];
  initial begin
    for (int i = 0; i < 128; i++) macro_mem[i] = '0;
    ram_do0 = '0;
  end
  always @(posedge wb_clk_i) begin
    if (ram_en0) begin
      for (int b = 0; b < 4; b++)
        if (ram_we0[b]) macro_mem[ram_a0][b*8 +: 8] <= ram_di0[b*8 +: 8];
      ram_do0 <= macro_mem[ram_a0];
    end else begin
      ram_do0 <= '0;
    end
  end

  // Expectation model: per-interval schedule indexed by posedge count.
  int          cyc_n = 0;
  bit          exp_ack [NCYC];
  bit          exp_en  [NCYC];
  bit [3:0]    exp_we  [NCYC];
  bit [6:0]    exp_a   [NCYC];
  bit [31:0]   exp_di  [NCYC];
  bit [31:0]   dat_sched [int];
  bit [31:0]   exp_dat = '0;
  bit [31:0]   ref_mem [128];
  int          errors = 0, checks = 0;
  int          ack_at = -1, en_cnt = 0, acc_cnt = 0;
  logic [6:0]  last_a0 = '0;
  bit          chk_on = 1'b0;

  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (chk_on && cyc_n < NCYC) begin
      if (dat_sched.exists(cyc_n)) exp_dat = dat_sched[cyc_n];
      check("ack", {31'b0, wbs_ack_o}, {31'b0, exp_ack[cyc_n]});
      check("en", {31'b0, ram_en0}, {31'b0, exp_en[cyc_n]});
      check("we", {28'b0, ram_we0}, {28'b0, exp_we[cyc_n]});
      check("dat_o", wbs_dat_o, exp_dat);
      if (exp_en[cyc_n]) begin
        check("a0", {25'b0, ram_a0}, {25'b0, exp_a[cyc_n]});
        check("di0", ram_di0, exp_di[cyc_n]);
      end
      if (ram_en0 === 1'b1) begin
        en_cnt++;
        last_a0 = ram_a0;
      end
      if (wbs_ack_o === 1'b1 && ack_at < 0) ack_at = cyc_n;
    end
  end

  // Called at a negedge; returns at a negedge with the bus idle and ready for the next request.
  task automatic xfer(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] dat, input bit drop, output int e0);
    int n, w, ack_iv;
    bit hit;
    n = cyc_n + 1;
    e0 = n;
    ack_at = -1;
    ack_iv = n;
    hit = (adr >= BASE) && (adr < BASE + WIN);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    if (hit) begin
      w = int'((adr - BASE) >> 2);
      acc_cnt++;
      exp_en[n] = 1'b1;
      exp_we[n] = we ? sel : 4'h0;
      exp_a[n]  = 7'(w);
      exp_di[n] = dat;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[w][b*8 +: 8] = dat[b*8 +: 8];
        ack_iv = n + 1;
      end else begin
        ack_iv = n + RDLAT;
        dat_sched[ack_iv] = ref_mem[w];
      end
      if (!drop) exp_ack[ack_iv] = 1'b1;
    end
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    if (!hit) begin
      repeat (16) @(negedge wb_clk_i);
    end else if (drop) begin
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (3) @(negedge wb_clk_i);
    end else begin
      while (cyc_n < ack_iv) @(negedge wb_clk_i);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge wb_clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int e0, n;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("reset_ack", {31'b0, wbs_ack_o}, 32'd0);
    check("reset_en", {31'b0, ram_en0}, 32'd0);
    check("reset_dat", wbs_dat_o, 32'd0);
    chk_on = 1'b1;
    @(negedge wb_clk_i);

    // Full write then read at word 4
    xfer(1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF, 1'b0, e0);
    check("wr_ack_latency", ack_at - e0, 32'd1);
    check("wr_a0_word4", {25'b0, last_a0}, 32'd4);
    xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0, 1'b0, e0);
    check("rd_ack_latency", ack_at - e0, RDLAT);
    check("rd_deadbeef", wbs_dat_o, 32'hDEADBEEF);

    // Byte-lane merge
    xfer(1'b1, 4'hF, BASE, 32'h11223344, 1'b0, e0);
    xfer(1'b1, 4'h1, BASE, 32'h000000AA, 1'b0, e0);
    xfer(1'b0, 4'hF, BASE, 32'h0, 1'b0, e0);
    check("rd_merge", wbs_dat_o, 32'h112233AA);

    // Just outside the window on both sides
    xfer(1'b0, 4'hF, BASE + WIN, 32'h0, 1'b0, e0);
    check("miss_above_noack", ack_at, -32'sd1);
    xfer(1'b1, 4'hF, BASE - 32'd4, 32'h12345678, 1'b0, e0);
    check("miss_below_noack", ack_at, -32'sd1);

    // Read data held while the macro output is zero
    xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0, 1'b0, e0);
    repeat (5) @(negedge wb_clk_i);
    check("hold_dat", wbs_dat_o, 32'hDEADBEEF);
    check("hold_do0_zero", ram_do0, 32'd0);

    // Last word, no aliasing onto word 0
    xfer(1'b1, 4'hF, BASE + 32'h1FC, 32'hCAFEF00D, 1'b0, e0);
    check("last_a0", {25'b0, last_a0}, 32'd127);
    xfer(1'b0, 4'hF, BASE, 32'h0, 1'b0, e0);
    check("no_alias_word0", wbs_dat_o, 32'h112233AA);
    xfer(1'b0, 4'hF, BASE + 32'h1FC, 32'h0, 1'b0, e0);
    check("rd_last", wbs_dat_o, 32'hCAFEF00D);

    // Master drops cyc after E0: no ack, write still lands
    xfer(1'b1, 4'hF, BASE + 32'h20, 32'h55AA55AA, 1'b1, e0);
    check("drop_noack", ack_at, -32'sd1);
    xfer(1'b0, 4'hF, BASE + 32'h20, 32'h0, 1'b0, e0);
    check("drop_committed", wbs_dat_o, 32'h55AA55AA);

    // sel=0 write: acked, memory and read data untouched
    xfer(1'b1, 4'h0, BASE + 32'h10, 32'hFFFFFFFF, 1'b0, e0);
    check("sel0_ack_latency", ack_at - e0, 32'd1);
    check("sel0_dat_kept", wbs_dat_o, 32'h55AA55AA);
    xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0, 1'b0, e0);
    check("sel0_mem_kept", wbs_dat_o, 32'hDEADBEEF);

    // Reset for two cycles in the middle of a read
    n = cyc_n + 1;
    ack_at = -1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = BASE + 32'h10; wbs_dat_i = 32'h0;
    acc_cnt++;
    exp_en[n] = 1'b1; exp_we[n] = 4'h0; exp_a[n] = 7'd4; exp_di[n] = 32'h0;
    dat_sched[n + 1] = 32'h0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("rst_mid_ack", {31'b0, wbs_ack_o}, 32'd0);
    check("rst_mid_en", {31'b0, ram_en0}, 32'd0);
    check("rst_mid_we", {28'b0, ram_we0}, 32'd0);
    check("rst_mid_dat", wbs_dat_o, 32'd0);
    check("rst_mid_noack", ack_at, -32'sd1);
    repeat (2) @(negedge wb_clk_i);
    xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0, 1'b0, e0);
    check("post_rst_read", wbs_dat_o, 32'hDEADBEEF);
    check("post_rst_latency", ack_at - e0, RDLAT);

    repeat (3) @(negedge wb_clk_i);
    check("en_cycles_per_access", en_cnt, acc_cnt);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
